// File: rtl/fifo_rd_drain_if.sv
// Handshake bundle for fifo_rd_drain: the FIFO read port on one side and
// the downstream valid/ready stream on the other.
// master: the drain controller. slave: the FIFO plus the downstream sink.
interface fifo_rd_drain_if #(
  parameter int WIDTH = 8
) ();
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_empty;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side consumer for the synchronous fifo.
// Issues fifo_rd_en, captures rd_data one cycle later into a 2-entry skid
// buffer (head r_h, tail r_t) and presents words as a valid/ready stream.
// At most two words are ever owed (buffered + in flight), so downstream
// back-pressure can never overflow the buffer; full rate is kept by letting
// this cycle's pop free a slot for this cycle's read (m_ready -> fifo_rd_en).
// Optional feature macro: FIFO_RD_DRAIN_CNT_EN adds the word_cnt output, a
// CNT_W-bit wrapping count of accepted downstream words.
module fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  fifo_rd_drain_if.master  bus,
  output logic             busy
`ifdef FIFO_RD_DRAIN_CNT_EN
  ,
  output logic [CNT_W-1:0] word_cnt
`endif
);

  logic             r_pend;
  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_h;
  logic [WIDTH-1:0] r_t;

  logic             w_pop;
  logic [1:0]       w_occ_left;
  logic [2:0]       w_load;
  logic             w_rd_en;
  logic             w_capture;

  // Buffer occupancy left after this cycle's pop, plus the word in flight.
  assign w_pop      = (r_occ != 2'd0) & bus.m_ready;
  assign w_occ_left = r_occ - {1'b0, w_pop};
  assign w_load     = {1'b0, w_occ_left} + {2'b00, r_pend};

  // Gated by rstn so no read reaches the FIFO while the block is held in reset.
  assign w_rd_en    = rstn & en & ~bus.fifo_empty & (w_load < 3'd2);
  assign w_capture  = r_pend;

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = (r_occ != 2'd0);
  assign bus.m_data     = r_h;
  assign busy           = r_pend | (r_occ != 2'd0);

  // Read-in-flight flag and occupancy: pop and capture in the same cycle cancel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      r_pend <= w_rd_en & ~bus.fifo_empty;
      r_occ  <= w_occ_left + {1'b0, r_pend};
    end
  end

  // Head register: takes the arriving word when the buffer drains to empty,
  // otherwise advances from the tail on a pop of a full buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h <= '0;
    end else if (w_capture && (w_occ_left == 2'd0)) begin
      r_h <= bus.fifo_rd_data;
    end else if (w_pop && (r_occ == 2'd2)) begin
      r_h <= r_t;
    end
  end

  // Tail register: takes the arriving word whenever one word stays buffered.
  always_ff @(posedge clk) begin
    if (w_capture && (w_occ_left == 2'd1)) begin
      r_t <= bus.fifo_rd_data;
    end
  end

`ifdef FIFO_RD_DRAIN_CNT_EN
  logic [CNT_W-1:0] r_word_cnt;

  // Accepted-word counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule
